// File: rtl/icache_ctrl_pkg.sv
// Shared constants, state encoding and address-split helpers for the
// direct-mapped instruction cache.
package icache_ctrl_pkg;

  localparam int DATA_WID  = 32;
  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_e;

  // Field widths of a byte address split as {tag, index, word offset, 2'b00}.
  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int words);
    return 30 - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Instruction-memory refill bus. mem_req/mem_addr are held by the cache until
// a one-cycle mem_rvalid pulse returns mem_rdata and completes that word.
interface icache_mem_if;
  import icache_ctrl_pkg::*;

  logic                mem_req;
  logic [31:0]         mem_addr;
  logic                mem_rvalid;
  logic [DATA_WID-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/icache_ctrl_array.sv
// Data, tag and valid storage for the instruction cache: combinational read
// port, one word/tag write port, and a single-cycle invalidate-all.
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter  int LINES = DEF_LINES,
  parameter  int WORDS = DEF_WORDS,
  localparam int OFF   = off_w(WORDS),
  localparam int IDX   = idx_w(LINES),
  localparam int TAG   = tag_w(LINES, WORDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX-1:0]      rd_idx,
  input  logic [OFF-1:0]      rd_off,
  output logic [DATA_WID-1:0] rd_word,
  output logic [TAG-1:0]      rd_tag,
  output logic                rd_valid,
  input  logic                wr_en,
  input  logic [IDX-1:0]      wr_idx,
  input  logic [OFF-1:0]      wr_off,
  input  logic [DATA_WID-1:0] wr_word,
  input  logic                tag_we,
  input  logic [TAG-1:0]      wr_tag,
  input  logic                set_valid,
  input  logic                inval_all
);

  logic [DATA_WID-1:0] data_q [LINES][WORDS];
  logic [TAG-1:0]      tag_q  [LINES];
  logic [LINES-1:0]    valid_q;

  // Payload storage carries no reset; only the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx][wr_off] <= wr_word;
    end
    if (tag_we) begin
      tag_q[wr_idx] <= wr_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (inval_all) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[wr_idx] <= set_valid;
    end
  end

  assign rd_word  = data_q[rd_idx][rd_off];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller: zero-latency hits,
// in-order word-by-word line refill on a miss, fence.i flush.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         pc_in,
  input  logic                flush,
  output logic [DATA_WID-1:0] inst_out,
  output logic                icache_stall,
  icache_mem_if.master        mem,
  output icache_state_e       state_dbg
);

  localparam int OFF  = off_w(WORDS);
  localparam int IDX  = idx_w(LINES);
  localparam int TAG  = tag_w(LINES, WORDS);
  localparam int BASE = TAG + IDX;

  logic [OFF-1:0]  pc_off;
  logic [IDX-1:0]  pc_idx;
  logic [TAG-1:0]  pc_tag;
  logic [BASE-1:0] pc_base;
  logic            unused_pc_bits;

  assign pc_off         = pc_in[OFF+1:2];
  assign pc_idx         = pc_in[IDX+OFF+1:OFF+2];
  assign pc_tag         = pc_in[31:IDX+OFF+2];
  assign pc_base        = pc_in[31:OFF+2];
  assign unused_pc_bits = ^pc_in[1:0];

  icache_state_e   state_q, state_d;
  logic [OFF-1:0]  cnt_q, cnt_d;
  logic [BASE-1:0] base_q, base_d;
  logic            flush_pend_q, flush_pend_d;

  logic [DATA_WID-1:0] rd_word;
  logic [TAG-1:0]      rd_tag;
  logic                rd_valid;
  logic                hit;
  logic                accept;
  logic                last_word;

  assign hit       = rd_valid && (rd_tag == pc_tag) && (state_q == IDLE);
  assign accept    = (state_q == REFILL) && mem.mem_rvalid;
  assign last_word = (cnt_q == OFF'(WORDS - 1));

  // Refill writes go to the latched miss line, never to the live pc_in line,
  // so a redirect mid-refill cannot corrupt another set.
  icache_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (pc_idx),
    .rd_off    (pc_off),
    .rd_word   (rd_word),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_en     (accept),
    .wr_idx    (base_q[IDX-1:0]),
    .wr_off    (cnt_q),
    .wr_word   (mem.mem_rdata),
    .tag_we    (accept && last_word),
    .wr_tag    (base_q[BASE-1:IDX]),
    .set_valid (!(flush_pend_q || flush)),
    .inval_all (flush)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    flush_pend_d = flush_pend_q;
    inst_out     = '0;
    icache_stall = 1'b1;
    mem.mem_req  = 1'b0;
    mem.mem_addr = '0;

    case (state_q)
      IDLE: begin
        if (hit) begin
          inst_out     = rd_word;
          icache_stall = 1'b0;
        end else begin
          state_d      = REFILL;
          base_d       = pc_base;
          cnt_d        = '0;
          flush_pend_d = 1'b0;
        end
      end
      REFILL: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = {base_q, cnt_q, 2'b00};
        if (flush) begin
          flush_pend_d = 1'b1;
        end
        if (accept) begin
          cnt_d = cnt_q + OFF'(1);
          if (last_word) begin
            state_d      = IDLE;
            flush_pend_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: memory model with a refill-address
// scoreboard, a hit vector table, and hand-written miss/flush/reset sequences.
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;

  localparam int LINES   = 16;
  localparam int WORDS   = 4;
  localparam int MEM_LAT = 2;
  // Each word: MEM_LAT cycles of request before the rvalid cycle, accepted on
  // the edge after that; the miss cycle overlaps the first word's wait.
  localparam int MISS_CYCLES = (MEM_LAT + 1) * WORDS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pc_in = 32'h0;
  logic          flush = 1'b0;
  logic [31:0]   inst_out;
  logic          icache_stall;
  icache_state_e state_dbg;

  icache_mem_if mem_bus ();

  icache_ctrl #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_in        (pc_in),
    .flush        (flush),
    .inst_out     (inst_out),
    .icache_stall (icache_stall),
    .mem          (mem_bus),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          mem_wc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_line(input logic [31:0] addr);
    logic [31:0] base;
    base = addr & ~32'(WORDS * 4 - 1);
    for (int i = 0; i < WORDS; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Memory model: answers each request MEM_LAT cycles later, data = address.
  initial begin
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_bus.mem_rvalid) begin
        mem_bus.mem_rvalid = 1'b0;
      end else if (mem_bus.mem_req) begin
        if (mem_wc == MEM_LAT - 1) begin
          mem_wc = 0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL mem_unexpected_req: got 0x%08h expected no request", mem_bus.mem_addr);
          end else begin
            check("mem_addr", mem_bus.mem_addr, exp_q.pop_front());
          end
          mem_bus.mem_rdata  = mem_bus.mem_addr;
          mem_bus.mem_rvalid = 1'b1;
        end else begin
          mem_wc++;
        end
      end else begin
        mem_wc = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_hit(input string name, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (icache_stall && cycles < 300);
    n_cmp++;
    if (icache_stall) begin
      n_err++;
      $display("FAIL %s_timeout: got stall=1 after %0d cycles expected stall=0", name, cycles);
    end
  endtask

  task automatic wait_addr(input string name, input logic [31:0] addr);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (mem_bus.mem_req && mem_bus.mem_addr == addr) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL %s_timeout: got addr 0x%08h expected 0x%08h", name, mem_bus.mem_addr, addr);
    end
  endtask

  task automatic run_miss(input string name, input logic [31:0] pc);
    int cyc;
    push_line(pc);
    @(posedge clk);
    #1 pc_in = pc;
    @(negedge clk);
    check({name, "_stall"}, 32'(icache_stall), 32'd1);
    check({name, "_inst_zero"}, inst_out, 32'h0);
    wait_hit(name, cyc);
    check({name, "_inst"}, inst_out, pc);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        exp_stall;
    logic [31:0] exp_inst;
    logic        exp_req;
  } vec_t;

  vec_t vecs[5];

  // ---------------- test ----------------
  initial begin
    int cyc;

    vecs[0] = '{pc: 32'h44, exp_stall: 1'b0, exp_inst: 32'h44, exp_req: 1'b0};
    vecs[1] = '{pc: 32'h48, exp_stall: 1'b0, exp_inst: 32'h48, exp_req: 1'b0};
    vecs[2] = '{pc: 32'h4C, exp_stall: 1'b0, exp_inst: 32'h4C, exp_req: 1'b0};
    vecs[3] = '{pc: 32'h40, exp_stall: 1'b0, exp_inst: 32'h40, exp_req: 1'b0};
    vecs[4] = '{pc: 32'h4C, exp_stall: 1'b0, exp_inst: 32'h4C, exp_req: 1'b0};

    // Reset state
    pc_in = 32'h40;
    #12;
    check("rst_stall", 32'(icache_stall), 32'd1);
    check("rst_inst", inst_out, 32'h0);
    check("rst_req", 32'(mem_bus.mem_req), 32'd0);
    check("rst_addr", mem_bus.mem_addr, 32'h0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));

    // 1. Cold miss and refill
    push_line(32'h40);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("cold_stall_now", 32'(icache_stall), 32'd1);
    wait_hit("cold", cyc);
    check("cold_penalty", 32'(cyc), 32'(MISS_CYCLES));
    check("cold_inst", inst_out, 32'h40);
    check("cold_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2. Hits after refill, one per cycle
    foreach (vecs[i]) begin
      @(posedge clk);
      #1 pc_in = vecs[i].pc;
      @(negedge clk);
      check("hit_stall", 32'(icache_stall), 32'(vecs[i].exp_stall));
      check("hit_inst", inst_out, vecs[i].exp_inst);
      check("hit_req", 32'(mem_bus.mem_req), 32'(vecs[i].exp_req));
    end

    // 3. Conflict eviction on the same index
    run_miss("evict_440", 32'h440);
    run_miss("evict_40", 32'h40);

    // 4. Flush while the second word is pending: line refilled twice
    push_line(32'h80);
    push_line(32'h80);
    @(posedge clk);
    #1 pc_in = 32'h80;
    wait_addr("flush_w1", 32'h84);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    wait_hit("flush_refill", cyc);
    check("flush_inst", inst_out, 32'h80);
    check("flush_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5. Flush in IDLE (old valids in flush cycle), then redirect mid-refill
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("idle_flush_old_valid", 32'(icache_stall), 32'd0);
    check("idle_flush_inst", inst_out, 32'h80);
    push_line(32'h80);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("after_flush_miss", 32'(icache_stall), 32'd1);
    wait_addr("redir_w1", 32'h84);
    push_line(32'h100);
    @(posedge clk);
    #1 pc_in = 32'h100;
    wait_hit("redirect", cyc);
    check("redirect_inst", inst_out, 32'h100);
    check("redirect_sb_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1 pc_in = 32'h80;
    @(negedge clk);
    check("redirect_old_line_stall", 32'(icache_stall), 32'd0);
    check("redirect_old_line_inst", inst_out, 32'h80);

    // 6. Asynchronous reset mid-refill
    run_miss("pre_reset_40", 32'h40);
    push_line(32'h200);
    @(posedge clk);
    #1 pc_in = 32'h200;
    wait_addr("rst_w1", 32'h204);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(mem_bus.mem_req), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'(IDLE));
    check("midrst_stall", 32'(icache_stall), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    pc_in = 32'h40;
    push_line(32'h40);
    rst_n = 1'b1;
    #1;
    check("postrst_40_miss", 32'(icache_stall), 32'd1);
    wait_hit("postrst", cyc);
    check("postrst_inst", inst_out, 32'h40);
    check("postrst_sb_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
